// File: rtl/tpram_burst_reader_if.sv
// -----------------------------------------------------------------------------
// tpram_burst_reader_if
//
// Bundles everything the burst reader exchanges with the outside world:
//   command side : start, base_addr, len_m1, abort  (to reader)
//                  busy, done                       (from reader)
//   RAM read port: rd_en, rd_addr (from reader), rd_data (to reader, one
//                  cycle after rd_en)
//   output stream: m_valid, m_data, m_last (from reader), m_ready (to reader)
//
// Stream handshake: a word transfers on every rising edge where m_valid and
// m_ready are both high. Once m_valid is raised, m_valid, m_data and m_last
// hold steady until that transfer happens. m_ready may change freely and does
// not depend on m_valid.
//
// Modports:
//   master - the burst reader itself
//   slave  - the environment (command source, RAM, stream consumer)
// -----------------------------------------------------------------------------
interface tpram_burst_reader_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] len_m1;
  logic          abort;
  logic          busy;
  logic          done;

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    input  start, base_addr, len_m1, abort, rd_data, m_ready,
    output busy, done, rd_en, rd_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, base_addr, len_m1, abort, rd_data, m_ready,
    input  busy, done, rd_en, rd_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/tpram_burst_reader.sv
// -----------------------------------------------------------------------------
// tpram_burst_reader
//
// Read-side burst engine for the 2^AW x DW two-port RAM. A start command
// launches a burst of len_m1+1 reads over a contiguous, wrapping address
// range. The RAM's one-cycle read latency is absorbed by a 2-entry buffer,
// and words leave as a valid/ready stream with a last marker.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   bus       - tpram_burst_reader_if.master (command, RAM read port, stream)
//   dbg_state - current FSM state (0 IDLE, 1 READ, 2 DRAIN)
// -----------------------------------------------------------------------------
module tpram_burst_reader #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tpram_burst_reader_if.master bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          done_q, done_d;

  logic [AW-1:0] addr_q;
  logic [AW-1:0] len_q;
  logic [AW:0]   issued_q;       // AW+1 bits: a full-depth burst counts to 2^AW
  logic          inflight_q;     // a read was issued last cycle
  logic          inflight_last_q;

  logic [DW-1:0] buf_data_q [2];
  logic [1:0]    buf_last_q;
  logic          head_q;
  logic [1:0]    count_q;

  logic          start_ok;
  logic          pop;
  logic          push;
  logic          issue;
  logic          last_issue;
  logic          tail;
  logic [2:0]    occ;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  // abort outranks start, so a simultaneous abort also suppresses a start.
  assign start_ok = (state_q == IDLE) && bus.start && !bus.abort;

  assign pop  = (count_q != 2'd0) && bus.m_ready;
  assign push = inflight_q;

  // Occupancy after this edge excluding a new read. Keeping it below 2
  // before issuing means buffered + in-flight never exceeds 2, so a captured
  // word always has a free slot, while one word per cycle is still sustained.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == READ) && (occ < 3'd2);

  assign last_issue = issue && (issued_q == {1'b0, len_q});

  // Two entries: the free slot is the head when empty, the other one otherwise.
  assign tail = head_q ^ count_q[0];

  assign bus.rd_en   = issue;
  assign bus.rd_addr = addr_q;
  assign bus.m_valid = (count_q != 2'd0);
  assign bus.m_data  = buf_data_q[head_q];
  assign bus.m_last  = (count_q != 2'd0) && buf_last_q[head_q];
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign dbg_state   = state_q;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = READ;
      end
      READ: begin
        if (bus.abort)       state_d = IDLE;
        else if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (pop && bus.m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Address / issue bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q   <= bus.base_addr;
        len_q    <= bus.len_m1;
        issued_q <= '0;
      end else if (issue) begin
        addr_q   <= addr_q + 1'b1;    // natural wrap at 2^AW
        issued_q <= issued_q + 1'b1;
      end
      // A read in flight during abort is dropped; its data is never captured.
      inflight_q      <= issue && !bus.abort;
      inflight_last_q <= last_issue;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry output buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= '0;
      head_q        <= 1'b0;
      count_q       <= '0;
    end else if (bus.abort) begin
      // In IDLE the buffer is already empty, so flushing is harmless there.
      head_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (push) begin
        buf_data_q[tail] <= bus.rd_data;
        buf_last_q[tail] <= inflight_last_q;
      end
      if (pop) head_q <= ~head_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_tpram_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_tpram_burst_reader
//
// Bench for tpram_burst_reader. A behavioural RAM answers reads one cycle
// late; the expected stream of every burst is RAM[(base+i) mod 256] for
// i = 0..len_m1 with the last flag on i = len_m1.
// -----------------------------------------------------------------------------
module tb_tpram_burst_reader;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  tpram_burst_reader_if #(.AW(8), .DW(16)) bus ();
  logic [1:0] dbg_state;

  tpram_burst_reader #(.AW(8), .DW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // Behavioural RAM read port: data appears the cycle after rd_en.
  logic [15:0] ram [256];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model / scoreboard
  // ---------------------------------------------------------------------------
  logic [16:0] exp_q [$];        // {last, data}
  logic [7:0]  addr_log [$];
  int          cyc0;
  int          issued, popped, max_out, first_v, last_v;
  int          ready_pct = 100;

  task automatic expect_burst(input logic [7:0] base, input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) begin
      logic [7:0] a;
      a = base + 8'(i);
      exp_q.push_back({(i == int'(len)), ram[a]});
    end
  endtask

  // Consumer readiness, re-drawn every cycle.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.m_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Stream monitor: order/content, last flag, stability while stalled,
  // issue count and occupancy.
  bit          stall_prev = 1'b0;
  logic [15:0] data_prev;
  logic        last_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", bus.m_valid, 1);
        check("stall_data",  bus.m_data,  data_prev);
        check("stall_last",  bus.m_last,  last_prev);
      end
      if (bus.rd_en) begin
        issued++;
        addr_log.push_back(bus.rd_addr);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", bus.m_data, 32'hFFFF_FFFF);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("word_data", bus.m_data, e[15:0]);
          check("word_last", bus.m_last, e[16]);
        end
        popped++;
        if (first_v < 0) first_v = cyc - cyc0;
        if (bus.m_last) last_v = cyc - cyc0;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      stall_prev = bus.m_valid && !bus.m_ready && !bus.abort;
      data_prev  = bus.m_data;
      last_prev  = bus.m_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Raises start in the current cycle (cycle 0), then checks cycle 1.
  task automatic start_burst(input logic [7:0] base, input logic [7:0] len, input int pct);
    #1;
    issued  = 0;
    popped  = 0;
    max_out = 0;
    first_v = -1;
    last_v  = -1;
    addr_log.delete();
    ready_pct = pct;
    expect_burst(base, len);
    cyc0 = cyc;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.len_m1    = len;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.base_addr = $urandom;
    bus.len_m1    = $urandom;
    @(negedge clk);
    check("c1_busy",    bus.busy,    1);
    check("c1_rd_en",   bus.rd_en,   1);
    check("c1_rd_addr", bus.rd_addr, base);
  endtask

  // Waits (bounded) for done and checks end-of-burst bookkeeping.
  task automatic wait_done(input logic [7:0] len, input bit timed);
    int n;
    n = 0;
    while (!bus.done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", bus.done, 1);
    check("done_busy", bus.busy, 0);
    check("issued_total", issued, int'(len) + 1);
    check("exp_empty", exp_q.size(), 0);
    check("occupancy_le3", (max_out <= 3), 1);
    if (timed) begin
      check("first_valid_cycle", first_v, 3);
      check("last_cycle", last_v, 3 + int'(len));
      check("done_cycle", cyc - cyc0, 4 + int'(len));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},   bus.rd_en,   0);
    check({tag, "_rd_addr"}, bus.rd_addr, 0);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_m_data"},  bus.m_data,  0);
    check({tag, "_m_last"},  bus.m_last,  0);
    check({tag, "_busy"},    bus.busy,    0);
    check({tag, "_done"},    bus.done,    0);
    check({tag, "_state"},   dbg_state,   0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_addr = '0;
    bus.len_m1    = '0;
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    ram[8'h10] = 16'hBEEF;
    for (int i = 0; i < 8; i++) ram[i] = 16'h1000 + 16'(i);

    #12 check_reset_outputs("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Single word
    start_burst(8'h10, 8'd0, 100);
    wait_done(8'd0, 1'b1);

    // Full-rate burst; the next burst starts in the done cycle
    start_burst(8'h00, 8'd7, 100);
    wait_done(8'd7, 1'b1);

    // Wrap-around
    start_burst(8'hFE, 8'd3, 100);
    wait_done(8'd3, 1'b1);
    check("wrap_n", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("wrap_a0", addr_log[0], 8'hFE);
      check("wrap_a1", addr_log[1], 8'hFF);
      check("wrap_a2", addr_log[2], 8'h00);
      check("wrap_a3", addr_log[3], 8'h01);
    end

    // Backpressure
    start_burst(8'($urandom), 8'd15, 40);
    wait_done(8'd15, 1'b0);

    // Abort in cycle 5 together with start
    @(negedge clk);
    start_burst(8'h40, 8'd31, 100);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.abort     = 1'b1;
    bus.start     = 1'b1;
    bus.base_addr = 8'h80;
    bus.len_m1    = 8'd3;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_m_valid", bus.m_valid, 0);
    check("abort_busy",    bus.busy,    0);
    check("abort_done",    bus.done,    0);
    check("abort_rd_en",   bus.rd_en,   0);
    check("abort_state",   dbg_state,   0);
    @(posedge clk);
    @(negedge clk);
    check("abort_ignored_busy", bus.busy, 0);
    check("abort_no_done",      bus.done, 0);
    exp_q.delete();
    start_burst(8'h90, 8'd5, 100);
    wait_done(8'd5, 1'b1);

    // Asynchronous reset during DRAIN
    @(negedge clk);
    start_burst(8'h20, 8'd3, 100);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_state", dbg_state, 2);
    check("pre_reset_valid", bus.m_valid, 1);
    rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    start_burst(8'h33, 8'd9, 100);
    wait_done(8'd9, 1'b1);

    // Random bursts
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b, l;
      b = 8'($urandom);
      l = 8'($urandom_range(0, 63));
      start_burst(b, l, $urandom_range(20, 100));
      wait_done(l, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpram_burst_reader.md
# tpram_burst_reader

Read-side burst engine for the 256x16 two-port RAM. On a start command it drives the RAM read channel (enable + address) across a contiguous, wrapping address range. It absorbs the RAM's one-cycle read latency in a 2-entry output buffer and presents the words as a valid/ready stream with a last marker. It sits between the RAM read port and any downstream consumer (packetiser, serial transmitter), complementing the producer that fills the RAM through the write port.

## Interface
- AW, 8, RAM address width; depth = 2^AW
- DW, 16, RAM data width
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  burst request, sampled only in IDLE
- base_addr  in  AW  first RAM address of the burst, sampled with start
- len_m1  in  AW  burst length minus one (1..2^AW words), sampled with start
- abort  in  1  cancel the current burst (synchronous)
- rd_en  out  1  RAM read enable (drives enb)
- rd_addr  out  AW  RAM read address (drives addrb)
- rd_data  in  DW  RAM read data (data_o_b); valid the cycle after rd_en
- m_valid  out  1  output word valid
- m_ready  in  1  consumer accepts word
- m_data  out  DW  output word
- m_last  out  1  marks the final word of the burst
- busy  out  1  high from accepted start until done or abort
- done  out  1  one-cycle pulse after the last word handshake

## Operation
- States:
  - IDLE: busy=0. start=1 latches base_addr into the address counter and len_m1 into the remaining-issue counter, then goes to READ.
  - READ: issues reads. Leaves for DRAIN once the issue count reaches len_m1+1.
  - DRAIN: no new reads. When the last word is handshaken, goes to IDLE and pulses done.
- Issue rule (READ only), combinational: rd_en = (count + inflight − pop) < 2.
  - count = buffered words (0..2).
  - inflight = rd_en registered one cycle.
  - pop = m_valid & m_ready.
  - This guarantees no overflow and sustains 1 word/cycle when m_ready is held high.
- Address:
  - rd_addr = address counter. It increments by 1 on each issued read and wraps 2^AW−1 → 0.
  - Issued-word counter is AW+1 bits.
- Capture: when inflight=1, rd_data is written into the buffer at the next clock edge.
- Buffer order: FIFO order is preserved.
  - m_data/m_valid come from the buffer head.
  - m_last is tracked per entry: set on the entry whose read index = len_m1.
- Output stability: m_valid, m_data and m_last must not change while m_valid=1 and m_ready=0.
- Simultaneous events:
  - start is ignored while busy=1.
  - abort has priority over start and all handshakes.
  - A push and a pop in the same cycle keep count unchanged.
- Abort (any non-IDLE state):
  - Next edge: state → IDLE, buffer flushed, inflight discarded, m_valid=0, busy=0.
  - No done pulse.
  - abort in IDLE is a no-op.
- rd_addr holds its last value when rd_en=0.

## Timing
- Reset values: rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. The state is IDLE and the buffer is empty.
- Reset mid-burst behaves as an immediate abort: everything returns to reset values asynchronously.
- Cycle numbering: start high in cycle 0.
  - busy=1 from cycle 1.
  - rd_en=1 with rd_addr=base_addr in cycle 1.
  - rd_data valid in cycle 2.
  - First m_valid in cycle 3.
- With m_ready held high, words appear in cycles 3..3+len_m1 with no gaps. m_last=1 in cycle 3+len_m1.
- done=1 and busy=0 in the cycle after the last handshake.
- The earliest next start is accepted in the done cycle (state is IDLE).
- Backpressure: with m_ready low and the buffer full, rd_en stays 0. No word is lost or duplicated.

## Test plan
- Single word: base=0x10, len_m1=0, RAM[0x10]=0xBEEF, m_ready=1.
  - One rd_en in cycle 1.
  - m_data=0xBEEF with m_valid=m_last=1 in cycle 3.
  - done in cycle 4.
- Full-rate burst: base=0x00, len_m1=7, RAM[i]=0x1000+i, m_ready=1.
  - 8 consecutive words 0x1000..0x1007 in cycles 3..10.
  - m_last only on 0x1007.
  - done in cycle 11.
- Wrap-around: base=0xFE, len_m1=3.
  - rd_addr sequence FE, FF, 00, 01.
  - Output RAM[FE], RAM[FF], RAM[00], RAM[01] in order.
- Backpressure: len_m1=15, m_ready a random ~40% duty.
  - All 16 words delivered in order, none dropped or duplicated.
  - Outputs stable while stalled.
  - Never more than 2 buffered words plus 1 in flight.
  - Issued reads total exactly 16.
- Abort and restart: abort in cycle 5 of a len_m1=31 burst, with start asserted in the same cycle.
  - m_valid=0, busy=0 next cycle; no done pulse; start ignored.
  - A new start 2 cycles later runs a clean burst from its own base.
- Async reset mid-burst: drop rst_n for half a cycle during DRAIN.
  - All outputs go to reset values immediately.
  - A subsequent burst completes correctly.
